// File: rtl/queue_reader_pkg.sv
// Shared types and constants for the queue_reader consumer: FSM state encoding,
// stall counter width and the lane-index width helper.
package queue_reader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int STALL_W = 16;

  // A single-entry word still needs a 1-bit lane register.
  function automatic int lane_w(input int pack);
    return (pack <= 1) ? 1 : $clog2(pack);
  endfunction

endpackage

// File: rtl/queue_reader_if.sv
// Queue pop-side and packed-word stream signals of queue_reader.
// master = the reader, slave = the Queue plus the downstream consumer.
interface queue_reader_if #(
  parameter int WIDTH = 2,
  parameter int PACK  = 4
);
  localparam int OUT_W = WIDTH * PACK;

  logic             q_empty;
  logic             q_pop;
  logic [WIDTH-1:0] q_data;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  q_empty, q_data, out_ready,
    output q_pop, out_data, out_valid
  );

  modport slave (
    output q_empty, q_data, out_ready,
    input  q_pop, out_data, out_valid
  );
endinterface

// File: rtl/queue_reader_ctl.sv
// Drain controller for queue_reader: sequences pop, capture, emit and finish.
// Status strobes are registered; q_pop alone is combinational on q_empty.
module queue_reader_ctl
  import queue_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic count_zero,
  input  logic q_empty,
  input  logic out_ready,
  input  logic last_entry,
  input  logic last_lane,
  output logic q_pop,
  output logic load,
  output logic capture,
  output logic emit,
  output logic fin,
  output logic busy
`ifdef QUEUE_READER_STALL_CNT_EN
  ,
  output logic stall
`endif
);

  state_t state;
  logic   last_word;

  // NOTE: non-blocking assignments, so every branch below reads pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_word <= 1'b0;
      capture   <= 1'b0;
      emit      <= 1'b0;
      fin       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      capture <= 1'b0;
      fin     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (count_zero) begin
            state <= FIN;
            fin   <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: if (!q_empty) begin
          state   <= WAIT;
          capture <= 1'b1;
        end
        WAIT: begin
          // Remember whether this word carries the final entry; EMIT needs it.
          last_word <= last_entry;
          if (last_entry || last_lane) begin
            state <= EMIT;
            emit  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        EMIT: if (out_ready) begin
          emit <= 1'b0;
          if (last_word) begin
            state <= FIN;
            fin   <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          emit  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q_pop = (state == FETCH) && !q_empty;
  assign load  = (state == IDLE) && start && !count_zero;

`ifdef QUEUE_READER_STALL_CNT_EN
  assign stall = ((state == FETCH) && q_empty) || (emit && !out_ready);
`endif

endmodule

// File: rtl/queue_reader.sv
// Pop-side consumer of the 2-bit-entry Queue: drains a programmed number of entries,
// packs PACK per word LSB-first. Optional stall counter: QUEUE_READER_STALL_CNT_EN.
module queue_reader
  import queue_reader_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int PACK  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  queue_reader_if.master   bus,
  output logic             busy,
  output logic             done
`ifdef QUEUE_READER_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int OUT_W  = WIDTH * PACK;
  localparam int LANE_W = lane_w(PACK);

  logic [CNT_W-1:0]  remaining;
  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  data_q;
  logic              load, capture, emit, fin;
  logic              last_entry, last_lane, lane_init;
`ifdef QUEUE_READER_STALL_CNT_EN
  logic              stall;
`endif

  assign last_entry = (remaining == CNT_W'(1));
  assign last_lane  = (lane == LANE_W'(PACK - 1));
  // A fresh word starts on a new drain or on any accepted word that is not the last.
  assign lane_init  = load || (emit && bus.out_ready && (remaining != '0));

  queue_reader_ctl u_ctl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count_zero (count == '0),
    .q_empty    (bus.q_empty),
    .out_ready  (bus.out_ready),
    .last_entry (last_entry),
    .last_lane  (last_lane),
    .q_pop      (bus.q_pop),
    .load       (load),
    .capture    (capture),
    .emit       (emit),
    .fin        (fin),
    .busy       (busy)
`ifdef QUEUE_READER_STALL_CNT_EN
    ,
    .stall      (stall)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      lane      <= '0;
    end else begin
      if (load)
        remaining <= count;
      else if (capture && remaining != '0)
        remaining <= remaining - CNT_W'(1);

      if (lane_init)
        lane <= '0;
      else if (capture)
        lane <= lane + LANE_W'(1);
    end
  end

  // Clearing on lane_init leaves unfilled upper lanes of a short final word at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (lane_init) begin
      data_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < PACK; i++)
        if (lane == LANE_W'(i)) data_q[i*WIDTH +: WIDTH] <= bus.q_data;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = emit;
  assign done          = fin;

`ifdef QUEUE_READER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (start && !busy)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + STALL_W'(1);
  end
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: behavioural Queue, packing reference model,
// directed scenarios followed by randomized drains.
module tb_queue_reader;

  localparam int WIDTH = 2;
  localparam int PACK  = 4;
  localparam int CNT_W = 8;
  localparam int OUT_W = WIDTH * PACK;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             busy, done;
`ifdef QUEUE_READER_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  queue_reader_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

  queue_reader #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
`ifdef QUEUE_READER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural Queue: registered pop data, empty flag from registered contents.
  logic [WIDTH-1:0] fifo[$];
  logic [WIDTH-1:0] ref_q[$];
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] qd         = '0;
  logic             push_en    = 1'b0;
  logic [WIDTH-1:0] push_val   = '0;
  int               sched_cyc[$];
  logic [WIDTH-1:0] sched_val[$];
  int               checks = 0;
  int               errors = 0;

  assign bus.q_empty = fifo_empty;
  assign bus.q_data  = qd;

  always @(posedge clk) begin
    if (bus.q_pop && fifo.size() != 0) qd <= fifo.pop_front();
    if (push_en) fifo.push_back(push_val);
    fifo_empty <= (fifo.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    push_val = v;
    push_en  = 1'b1;
    ref_q.push_back(v);
    @(negedge clk);
    push_en  = 1'b0;
  endtask

  task automatic schedule(input int cyc, input logic [WIDTH-1:0] v);
    sched_cyc.push_back(cyc);
    sched_val.push_back(v);
    ref_q.push_back(v);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for the first 5 valid cycles of each word.
  task automatic drain(input string tag, input int cnt, input int rmode, input bit poke_start);
    logic [OUT_W-1:0] exp_w[$];
    logic [OUT_W-1:0] w, prev_data;
    logic [WIDTH-1:0] e;
    int  cyc, pops, words_exp, words_got, done_cnt, done_cyc, hs_cyc, bad_pop, bad_hold, low_left;
    bit  prev_valid, prev_acc, prev_pop, acc, finished;

    w = '0;
    for (int i = 0; i < cnt; i++) begin
      if (i % PACK == 0) w = '0;
      e = ref_q.pop_front();
      w = w | (OUT_W'(e) << (WIDTH * (i % PACK)));
      if (i % PACK == PACK - 1 || i == cnt - 1) exp_w.push_back(w);
    end
    words_exp = exp_w.size();
    pops = 0; words_got = 0; done_cnt = 0; done_cyc = -1; hs_cyc = -100;
    bad_pop = 0; bad_hold = 0; low_left = 5; finished = 1'b0;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_pop = 1'b0; prev_data = '0;

    start = 1'b1;
    count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!finished && cyc < 3000) begin
      push_en = 1'b0;
      if (bus.q_pop) begin
        pops++;
        if (bus.q_empty || prev_pop) bad_pop++;
      end
      if (bus.out_valid && bus.q_pop) bad_hold++;
      if (prev_valid && !prev_acc && bus.out_valid && bus.out_data !== prev_data) bad_hold++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.out_valid && low_left > 0) begin
            bus.out_ready = 1'b0;
            low_left--;
          end else begin
            bus.out_ready = bus.out_valid;
          end
        end
      endcase
      acc = bus.out_valid && bus.out_ready;
      if (acc) begin
        words_got++;
        hs_cyc   = cyc;
        low_left = 5;
        if (exp_w.size() != 0) check({tag, " word"}, 32'(bus.out_data), 32'(exp_w.pop_front()));
        else check({tag, " unexpected word"}, 32'(bus.out_data), 32'hFFFF_FFFF);
      end
      if (sched_cyc.size() != 0 && sched_cyc[0] == cyc) begin
        push_en  = 1'b1;
        push_val = sched_val.pop_front();
        void'(sched_cyc.pop_front());
      end
      start = poke_start && (cyc == 3) && !finished;
      if (start) count = CNT_W'($urandom_range(1, 9));
      prev_valid = bus.out_valid;
      prev_acc   = acc;
      prev_pop   = bus.q_pop;
      prev_data  = bus.out_data;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start         = 1'b0;
    push_en       = 1'b0;
    bus.out_ready = 1'b0;

    check({tag, " pops"}, pops, cnt);
    check({tag, " words"}, words_got, words_exp);
    check({tag, " done pulses"}, done_cnt, 1);
    if (cnt != 0) check({tag, " done latency"}, done_cyc - hs_cyc, 1);
    check({tag, " pop rules"}, bad_pop, 0);
    check({tag, " hold rules"}, bad_hold, 0);
    @(negedge clk);
    check({tag, " idle after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int pops, bad, c, n, pre;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset outputs", {bus.q_pop, bus.out_valid, bus.out_data, busy, done}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: four preloaded entries form one word
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    drain("t1", 4, 0, 1'b0);

    // 2: six entries, second word partially filled
    push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd2); push(2'd1);
    drain("t2", 6, 0, 1'b0);

    // 3: queue empty at start, entries trickle in
    schedule(10, 2'd3);
    schedule(20, 2'd1);
    drain("t3", 2, 0, 1'b0);
`ifdef QUEUE_READER_STALL_CNT_EN
    check("t3 stall_cnt at least 10", 32'(stall_cnt >= 16'd10), 32'd1);
`endif

    // 4: downstream backpressure for 5 cycles
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    drain("t4", 4, 2, 1'b0);
`ifdef QUEUE_READER_STALL_CNT_EN
    check("t4 stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // 5: zero-length drain, start in FIN ignored
    start = 1'b1;
    count = '0;
    @(negedge clk);
    check("t5 fin cycle", {busy, done, bus.q_pop}, 3'b110);
    start = 1'b1;
    count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    check("t5 after fin", {busy, done}, 2'b00);
    @(negedge clk);
    check("t5 start in fin ignored", {busy, bus.q_pop}, 2'b00);

    // 6: reset in the middle of a word
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    start = 1'b1;
    count = CNT_W'(4);
    @(negedge clk);
    start = 1'b0;
    pops  = 0;
    for (int i = 0; i < 50 && pops < 2; i++) begin
      if (bus.q_pop) pops++;
      @(negedge clk);
    end
    check("t6 pops before reset", pops, 2);
    rst = 1'b0;
    #1;
    check("t6 outputs in reset", {bus.q_pop, bus.out_valid, bus.out_data, busy, done}, '0);
    void'(ref_q.pop_front());
    void'(ref_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.q_pop || busy) bad++;
    end
    check("t6 no pop after release", bad, 0);
    drain("t6", 1, 0, 1'b0);
    drain("t6 tail", 1, 0, 1'b0);

    // Randomized drains: random entries, arrival times, backpressure and busy starts
    for (int r = 0; r < 6; r++) begin
      n   = $urandom_range(1, 11);
      pre = $urandom_range(0, n);
      for (int i = 0; i < pre; i++) push(WIDTH'($urandom_range(0, 3)));
      c = 0;
      for (int i = pre; i < n; i++) begin
        c += $urandom_range(1, 5);
        schedule(c, WIDTH'($urandom_range(0, 3)));
      end
      drain("rnd", n, 1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
